// File: rtl/seg_decoder_if.sv
// Handshake bundle between a segment-pattern source, the seg_decoder and the
// consumer of the assembled BCD frames.
interface seg_decoder_if #(
    parameter int NDIGITS = 4
);
    logic [7:0]           seg_in;
    logic                 seg_valid;
    logic                 seg_ready;
    logic [4*NDIGITS-1:0] out_bcd;
    logic                 out_err;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output seg_in,
        output seg_valid,
        output out_ready,
        input  seg_ready,
        input  out_bcd,
        input  out_err,
        input  out_valid
    );

    modport slave (
        input  seg_in,
        input  seg_valid,
        input  out_ready,
        output seg_ready,
        output out_bcd,
        output out_err,
        output out_valid
    );
endinterface

// File: rtl/seg_decoder.sv
// Seven-segment pattern decoder: maps each accepted pattern back to a BCD
// nibble and assembles NDIGITS nibbles into one frame under valid/ready.
module seg_decoder #(
    parameter int NDIGITS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_decoder_if.slave  bus
);
    localparam int DW = 4 * NDIGITS;
    localparam int CW = $clog2(NDIGITS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NDIGITS - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   dig_q, dig_d;
    logic            err_q, err_d;
    logic [DW-1:0]   out_bcd_q, out_bcd_d;
    logic            out_err_q, out_err_d;
    logic            out_valid_q, out_valid_d;

    logic [3:0]      dec_nib;
    logic            dec_illegal;
    logic [DW+3:0]   dig_shift;
    logic            accept;
    logic            unused_dp;

    // The decimal point carries no digit information.
    assign unused_dp = bus.seg_in[0];

    always_comb begin
        dec_nib     = 4'hE;
        dec_illegal = 1'b1;
        case (bus.seg_in[7:1])
            7'h7E: begin dec_nib = 4'h0; dec_illegal = 1'b0; end
            7'h30: begin dec_nib = 4'h1; dec_illegal = 1'b0; end
            7'h6D: begin dec_nib = 4'h2; dec_illegal = 1'b0; end
            7'h79: begin dec_nib = 4'h3; dec_illegal = 1'b0; end
            7'h33: begin dec_nib = 4'h4; dec_illegal = 1'b0; end
            7'h5B: begin dec_nib = 4'h5; dec_illegal = 1'b0; end
            7'h5F: begin dec_nib = 4'h6; dec_illegal = 1'b0; end
            7'h70: begin dec_nib = 4'h7; dec_illegal = 1'b0; end
            7'h7F: begin dec_nib = 4'h8; dec_illegal = 1'b0; end
            7'h7B: begin dec_nib = 4'h9; dec_illegal = 1'b0; end
            7'h00: begin dec_nib = 4'hF; dec_illegal = 1'b0; end
            default: begin dec_nib = 4'hE; dec_illegal = 1'b1; end
        endcase
    end

    // Widened concatenation keeps the shift legal when NDIGITS is 1.
    assign dig_shift = {dig_q, dec_nib};
    assign accept    = (state_q == COLLECT) && bus.seg_valid;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dig_d       = dig_q;
        err_d       = err_q;
        out_bcd_d   = out_bcd_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    dig_d = dig_shift[DW-1:0];
                    err_d = err_q | dec_illegal;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d     = HOLD;
                        out_bcd_d   = dig_shift[DW-1:0];
                        out_err_d   = err_q | dec_illegal;
                        out_valid_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d     = COLLECT;
                    cnt_d       = '0;
                    dig_d       = '0;
                    err_d       = 1'b0;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            dig_q       <= '0;
            err_q       <= 1'b0;
            out_bcd_q   <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dig_q       <= dig_d;
            err_q       <= err_d;
            out_bcd_q   <= out_bcd_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.seg_ready = (state_q == COLLECT);
    assign bus.out_bcd   = out_bcd_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_valid = out_valid_q;
endmodule
